// File: rtl/inst_prefetch_queue_pkg.sv
// +------------------------------------------------------------------------+
// | inst_prefetch_queue_pkg - shared widths, NOP encoding, fetch FSM states |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package inst_prefetch_queue_pkg;

  localparam int          PQ_XLEN   = 32;
  localparam int          PQ_INST_W = 32;
  localparam logic [31:0] PQ_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pq_fifo.sv
// +------------------------------------------------------------------------+
// | pq_fifo - synchronous FIFO with push, pop, flush and occupancy count   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module pq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rptr];
  assign o_count   = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
// +------------------------------------------------------------------------+
// | inst_prefetch_queue - single-outstanding fetch FSM feeding a FIFO      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int              XLEN     = PQ_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_redirect_valid,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_imem_req,
  output logic [XLEN-1:0]          o_imem_addr,
  input  logic                     i_imem_ready,
  input  logic [PQ_INST_W-1:0]     i_imem_rdata,
  output logic                     o_deq_valid,
  output logic [PQ_INST_W-1:0]     o_deq_inst,
  output logic [XLEN-1:0]          o_deq_pc,
  input  logic                     i_deq_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam int              EW      = PQ_INST_W + XLEN;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_e    r_state, w_state_nxt;
  logic            r_req, w_req_nxt;
  logic [XLEN-1:0] r_addr, w_addr_nxt;
  logic [XLEN-1:0] r_target, w_target_nxt;

  logic            w_hs;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [EW-1:0]   w_head;
  logic [CW-1:0]   w_cnt_next;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_unused;

  assign w_unused   = ^i_redirect_pc[1:0];
  assign w_redir_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
  assign w_hs       = r_req & i_imem_ready;
  // Redirect outranks both queue operations; the FIFO is flushed instead.
  assign w_push     = (r_state == ST_FETCH) & w_hs & ~i_redirect_valid;
  assign w_pop      = o_deq_valid & i_deq_ready & ~i_redirect_valid;
  assign w_cnt_next = o_count + CW'(w_push) - CW'(w_pop);

  pq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({i_imem_rdata, r_addr}),
    .i_pop       (w_pop),
    .i_flush     (i_redirect_valid),
    .o_head      (w_head),
    .o_count     (o_count),
    .o_empty     (w_empty)
  );

  assign o_deq_valid = ~w_empty;
  assign o_deq_inst  = w_empty ? PQ_NOP : w_head[EW-1 -: PQ_INST_W];
  assign o_deq_pc    = w_empty ? '0 : w_head[XLEN-1:0];
  assign o_imem_req  = r_req;
  assign o_imem_addr = r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_FETCH;
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_target <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_addr   <= w_addr_nxt;
      r_target <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_addr_nxt   = r_addr;
    w_target_nxt = r_target;
    case (r_state)
      ST_FETCH: begin
        if (i_redirect_valid) begin
          // A request already on the bus cannot be withdrawn; drain it first.
          if (r_req && !i_imem_ready) begin
            w_state_nxt  = ST_DRAIN;
            w_target_nxt = w_redir_pc;
          end else begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_redir_pc;
          end
        end else if (w_hs) begin
          w_addr_nxt = r_addr + PC_STEP;
          if (w_cnt_next == CW'(DEPTH)) begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
          end else begin
            w_req_nxt = 1'b1;
          end
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_redirect_valid) w_target_nxt = w_redir_pc;
        if (w_hs) begin
          w_state_nxt = ST_FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = i_redirect_valid ? w_redir_pc : r_target;
        end
      end
      ST_IDLE: begin
        if (i_redirect_valid) begin
          w_state_nxt = ST_FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = w_redir_pc;
        end else if (w_pop) begin
          w_state_nxt = ST_FETCH;
          w_req_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
// +------------------------------------------------------------------------+
// | tb_inst_prefetch_queue - directed stimulus with scoreboard monitor     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_inst_prefetch_queue;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready = 1'b0;
  logic [31:0] i_imem_rdata;
  logic        o_deq_valid;
  logic [31:0] o_deq_inst;
  logic [31:0] o_deq_pc;
  logic        i_deq_ready = 1'b0;
  logic [2:0]  o_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_deq_q[$];

  always #5 clk = ~clk;

  // Memory model: instruction word is a fixed function of its address.
  assign i_imem_rdata = o_imem_addr ^ KEY;

  inst_prefetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_ready     (i_imem_ready),
    .i_imem_rdata     (i_imem_rdata),
    .o_deq_valid      (o_deq_valid),
    .o_deq_inst       (o_deq_inst),
    .o_deq_pc         (o_deq_pc),
    .i_deq_ready      (i_deq_ready),
    .o_count          (o_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake and every pop consumes one scoreboard entry.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (o_imem_req && i_imem_ready) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL hs_unexpected actual=%h required=none", o_imem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          if (o_imem_addr !== e) begin
            errors++;
            $display("FAIL hs_addr actual=%h required=%h", o_imem_addr, e);
          end
        end
      end
      if (o_deq_valid && i_deq_ready && !i_redirect_valid) begin
        checks++;
        if (exp_deq_q.size() == 0) begin
          errors++;
          $display("FAIL deq_unexpected actual=%h required=none", o_deq_pc);
        end else begin
          e = exp_deq_q.pop_front();
          if (o_deq_pc !== e || o_deq_inst !== (e ^ KEY)) begin
            errors++;
            $display("FAIL deq_entry actual=%h/%h required=%h/%h",
                     o_deq_pc, o_deq_inst, e, e ^ KEY);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    step(2);
    chk("rst_req", {31'b0, o_imem_req}, 32'd0);
    chk("rst_count", {29'b0, o_count}, 32'd0);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_deq_valid", {31'b0, o_deq_valid}, 32'd0);
    chk("rst_deq_inst", o_deq_inst, NOP);
    chk("rst_deq_pc", o_deq_pc, 32'h0);
    rst = 1'b0;
    step(1);
    chk("first_req", {31'b0, o_imem_req}, 32'd1);
    chk("first_addr", o_imem_addr, 32'h0);

    // Fill to full with decode stalled
    exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    i_imem_ready = 1'b1;
    step(4);
    chk("full_req", {31'b0, o_imem_req}, 32'd0);
    chk("full_count", {29'b0, o_count}, 32'd4);
    chk("full_head_pc", o_deq_pc, 32'h0);
    step(2);
    chk("full_hold_count", {29'b0, o_count}, 32'd4);
    chk("full_hold_req", {31'b0, o_imem_req}, 32'd0);

    // One pop reopens fetch at 0x10
    exp_addr_q.push_back(32'h10);
    exp_deq_q.push_back(32'h0);
    i_deq_ready = 1'b1;
    step(1);
    i_deq_ready = 1'b0;
    chk("resume_req", {31'b0, o_imem_req}, 32'd1);
    chk("resume_addr", o_imem_addr, 32'h10);
    chk("resume_count", {29'b0, o_count}, 32'd3);
    step(1);
    chk("refull_count", {29'b0, o_count}, 32'd4);
    chk("refull_req", {31'b0, o_imem_req}, 32'd0);

    // Redirect from IDLE, then stream at one instruction per cycle
    exp_addr_q = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210};
    exp_deq_q  = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h210};
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h200;
    step(1);
    i_redirect_valid = 1'b0;
    chk("redir_count", {29'b0, o_count}, 32'd0);
    chk("redir_deq_valid", {31'b0, o_deq_valid}, 32'd0);
    chk("redir_addr", o_imem_addr, 32'h200);
    i_deq_ready = 1'b1;
    step(2);
    chk("stream_count", {29'b0, o_count}, 32'd1);
    step(3);
    i_imem_ready = 1'b0;
    step(2);
    chk("stream_end_count", {29'b0, o_count}, 32'd0);
    chk("stream_end_addr", o_imem_addr, 32'h214);

    // Redirect while pending, re-redirect during drain
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h100;
    step(1);
    i_redirect_pc = 32'h300;
    chk("drain_addr0", o_imem_addr, 32'h214);
    chk("drain_req0", {31'b0, o_imem_req}, 32'd1);
    step(1);
    i_redirect_valid = 1'b0;
    chk("drain_addr1", o_imem_addr, 32'h214);
    step(1);
    chk("drain_addr2", o_imem_addr, 32'h214);
    exp_addr_q = '{32'h214, 32'h300, 32'h304};
    exp_deq_q  = '{32'h300, 32'h304};
    i_imem_ready = 1'b1;
    step(1);
    chk("drain_done_addr", o_imem_addr, 32'h300);
    chk("drain_done_count", {29'b0, o_count}, 32'd0);
    chk("drain_done_valid", {31'b0, o_deq_valid}, 32'd0);
    step(2);
    i_imem_ready = 1'b0;
    step(2);
    chk("drain_end_count", {29'b0, o_count}, 32'd0);

    // Redirect to unaligned 0x102 with 3 entries, handshake same cycle
    i_deq_ready = 1'b0;
    exp_addr_q = '{32'h308, 32'h30C, 32'h310, 32'h314};
    i_imem_ready = 1'b1;
    step(3);
    chk("three_count", {29'b0, o_count}, 32'd3);
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'h102;
    step(1);
    i_redirect_valid = 1'b0;
    i_imem_ready = 1'b0;
    chk("align_count", {29'b0, o_count}, 32'd0);
    chk("align_valid", {31'b0, o_deq_valid}, 32'd0);
    chk("align_addr", o_imem_addr, 32'h100);
    chk("align_req", {31'b0, o_imem_req}, 32'd1);

    // Address wrap at the top of the space
    exp_addr_q = '{32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    exp_deq_q  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    i_redirect_valid = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF8;
    i_imem_ready = 1'b1;
    step(1);
    i_redirect_valid = 1'b0;
    i_deq_ready = 1'b1;
    chk("wrap_addr0", o_imem_addr, 32'hFFFF_FFF8);
    step(3);
    i_imem_ready = 1'b0;
    step(2);
    chk("wrap_count", {29'b0, o_count}, 32'd0);
    chk("wrap_addr_next", o_imem_addr, 32'h4);

    // Reset with a request pending
    i_deq_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, o_imem_req}, 32'd0);
    chk("arst_count", {29'b0, o_count}, 32'd0);
    chk("arst_addr", o_imem_addr, 32'h0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("rel_req", {31'b0, o_imem_req}, 32'd1);
    chk("rel_addr", o_imem_addr, 32'h0);

    chk("leftover_hs", exp_addr_q.size(), 32'd0);
    chk("leftover_deq", exp_deq_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
